// File: rtl/pc_unit_pkg.sv
// pc_pkg: shared next-PC select encoding for pc_unit and its control FSM.
// Optional return-address stack is enabled by defining PC_RAS_EN.
package pc_pkg;

    localparam int unsigned PCS_W = 3;

    typedef enum logic [PCS_W-1:0] {
        PCS_SEQ  = 3'd0,  // pc + INCR
        PCS_BR   = 3'd1,  // pc + offset when cond, else pc + INCR
        PCS_JMP  = 3'd2,  // target
        PCS_CALL = 3'd3,  // target, link pc + INCR
        PCS_RET  = 3'd4,  // popped return address
        PCS_TRAP = 3'd5,  // TRAP_VECTOR
        PCS_HOLD = 3'd6   // pc (7 also decodes as hold)
    } pcsource_e;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/fetch-side bundle of the program-counter unit.
// Handshake: there is no valid/ready pair; pcen is the single qualifier.
// When pcen=1 the PC, RAS and sticky flags advance on the next rising clk
// edge; when pcen=0 nothing changes, while nextpc still shows the selection.
interface pc_unit_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAS_DEPTH = 8
);
    import pc_pkg::*;

    localparam int unsigned DW = $clog2(RAS_DEPTH + 1);

    logic             pcen;
    logic [PCS_W-1:0] pcsource;
    logic             cond;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] nextpc;
    logic [DW-1:0]    ras_depth;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output pcen, pcsource, cond, offset, target,
        input  pc, nextpc, ras_depth, ras_ovf, ras_unf
    );

    modport slave (
        input  pcen, pcsource, cond, offset, target,
        output pc, nextpc, ras_depth, ras_ovf, ras_unf
    );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular LIFO of return addresses. A push when full overwrites
// the oldest entry (pointer wraps, count saturates); a pop when empty is
// ignored. Only built when PC_RAS_EN is defined.
module ras_stack #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [WIDTH-1:0]                 push_data_i,
    output logic [WIDTH-1:0]                 top_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   depth_o,
    output logic                             full_o,
    output logic                             empty_o
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned DW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [DW-1:0]    cnt_q, cnt_d;

    assign full_o  = (cnt_q == DW'(RAS_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign top_o   = mem_q[ptr_q];
    assign depth_o = cnt_q;

    // Next pointer/count: push pre-increments, pop post-decrements.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            if (!full_o) begin
                cnt_d = cnt_q + DW'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - DW'(1);
        end
    end

    // Pointer and count registers; reset empties the stack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_d] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register plus next-PC mux (seq, branch, jump, call, return,
// trap). Define PC_RAS_EN to build the return-address stack and its sticky
// overflow/underflow flags; otherwise RET goes to target and CALL is a jump.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned INCR         = 1,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned TRAP_VECTOR  = 2,
    parameter int unsigned RAS_DEPTH    = 8
) (
    input  logic      clk,
    input  logic      reset,
    pc_unit_if.slave  bus
);
    localparam int unsigned DW = $clog2(RAS_DEPTH + 1);

    pcsource_e        src;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] nextpc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_br;
    logic [WIDTH-1:0] ret_addr;

    assign src    = pcsource_e'(bus.pcsource);
    // Additions wrap modulo 2^WIDTH; the carry is simply dropped.
    assign pc_inc = pc_q + WIDTH'(INCR);
    assign pc_br  = pc_q + bus.offset;

`ifdef PC_RAS_EN
    logic             is_call, is_ret;
    logic             push, pop;
    logic             ras_full, ras_empty;
    logic [WIDTH-1:0] ras_top;
    logic [DW-1:0]    ras_cnt;
    logic             ovf_q, unf_q;

    assign is_call  = (src == PCS_CALL);
    assign is_ret   = (src == PCS_RET);
    assign push     = bus.pcen && is_call;
    assign pop      = bus.pcen && is_ret && !ras_empty;
    // Returning with nothing stacked is treated as a trap.
    assign ret_addr = ras_empty ? WIDTH'(TRAP_VECTOR) : ras_top;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .depth_o     (ras_cnt),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    // Sticky overflow/underflow flags; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.pcen) begin
            if (is_call && ras_full) begin
                ovf_q <= 1'b1;
            end
            if (is_ret && ras_empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.ras_depth = ras_cnt;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
`else
    // Register-indirect return: the caller supplies the address on target.
    assign ret_addr      = bus.target;
    assign bus.ras_depth = {DW{1'b0}};
    assign bus.ras_ovf   = 1'b0;
    assign bus.ras_unf   = 1'b0;
`endif

    // Next-PC select, valid regardless of pcen.
    always_comb begin
        nextpc_d = pc_q;
        case (src)
            PCS_SEQ:  nextpc_d = pc_inc;
            PCS_BR:   nextpc_d = bus.cond ? pc_br : pc_inc;
            PCS_JMP:  nextpc_d = bus.target;
            PCS_CALL: nextpc_d = bus.target;
            PCS_RET:  nextpc_d = ret_addr;
            PCS_TRAP: nextpc_d = WIDTH'(TRAP_VECTOR);
            default:  nextpc_d = pc_q;
        endcase
    end

    // PC register; pcen=0 is a full stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= WIDTH'(RESET_VECTOR);
        end else if (bus.pcen) begin
            pc_q <= nextpc_d;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.nextpc = nextpc_d;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed bench for pc_unit. Covers both builds; expectations
// for CALL/RET follow whether PC_RAS_EN is defined.
`timescale 1ns/1ps
module tb_pc_unit;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(16), .RAS_DEPTH(8)) bus ();

    pc_unit #(
        .WIDTH        (16),
        .INCR         (1),
        .RESET_VECTOR (16'h0010),
        .TRAP_VECTOR  (2),
        .RAS_DEPTH    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  src;
        logic        c;
        logic        en;
        logic [15:0] off;
        logic [15:0] tgt;
        logic [15:0] exp_nxt;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ras(input string name, input logic [15:0] d, input logic o, input logic u);
        chk({name, "_depth"}, 16'(bus.ras_depth), d);
        chk({name, "_ovf"}, 16'(bus.ras_ovf), 16'(o));
        chk({name, "_unf"}, 16'(bus.ras_unf), 16'(u));
    endtask

    // Apply inputs just after an edge and let the mux settle.
    task automatic drive(input logic [2:0] src, input logic c, input logic en,
                         input logic [15:0] off, input logic [15:0] tgt);
        bus.pcsource = src;
        bus.cond     = c;
        bus.pcen     = en;
        bus.offset   = off;
        bus.target   = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0011, 16'h0011};
        tbl[1]  = '{3'd2, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[2]  = '{3'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[3]  = '{3'd1, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 16'hFFFE, 16'hFFFE};
        tbl[4]  = '{3'd1, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'hFFFF, 16'hFFFF};
        tbl[5]  = '{3'd1, 1'b1, 1'b1, 16'h0005, 16'h0000, 16'h0004, 16'h0004};
        tbl[6]  = '{3'd5, 1'b0, 1'b1, 16'h0000, 16'h4444, 16'h0002, 16'h0002};
        tbl[7]  = '{3'd6, 1'b1, 1'b1, 16'h0040, 16'h5555, 16'h0002, 16'h0002};
        tbl[8]  = '{3'd7, 1'b1, 1'b1, 16'h0040, 16'h5555, 16'h0002, 16'h0002};
        tbl[9]  = '{3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'h0002};
        tbl[10] = '{3'd2, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h1234, 16'h0002};
        tbl[11] = '{3'd1, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0012, 16'h0012};

        // Reset asserted mid-cycle must act before any clock edge.
        reset = 1'b1;
        drive(3'd6, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_pc", bus.pc, 16'h0010);
        chk_ras("reset", 16'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;

        // Datapath vectors: seq, branch, wrap, jump, trap, hold, stall.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].src, tbl[i].c, tbl[i].en, tbl[i].off, tbl[i].tgt);
            chk($sformatf("vec%0d_nextpc", i), bus.nextpc, tbl[i].exp_nxt);
            tick();
            chk($sformatf("vec%0d_pc", i), bus.pc, tbl[i].exp_pc);
        end

`ifdef PC_RAS_EN
        // Nested call/return.
        drive(PCS_JMP, 1'b0, 1'b1, 16'h0000, 16'h0100);
        tick();
        drive(PCS_CALL, 1'b0, 1'b1, 16'h0000, 16'h0200);
        chk("call1_nextpc", bus.nextpc, 16'h0200);
        tick();
        chk("call1_pc", bus.pc, 16'h0200);
        chk_ras("call1", 16'd1, 1'b0, 1'b0);
        drive(PCS_CALL, 1'b0, 1'b1, 16'h0000, 16'h0300);
        tick();
        chk("call2_pc", bus.pc, 16'h0300);
        chk_ras("call2", 16'd2, 1'b0, 1'b0);
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0AAA);
        chk("ret1_nextpc", bus.nextpc, 16'h0201);
        tick();
        chk("ret1_pc", bus.pc, 16'h0201);
        chk_ras("ret1", 16'd1, 1'b0, 1'b0);
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0AAA);
        tick();
        chk("ret2_pc", bus.pc, 16'h0101);
        chk_ras("ret2", 16'd0, 1'b0, 1'b0);

        // Stall: nothing may change while pcen=0.
        for (int k = 0; k < 3; k++) begin
            drive(PCS_RET, 1'b0, 1'b0, 16'h0000, 16'h0AAA);
            chk("stall_ret_nextpc", bus.nextpc, 16'h0002);
            tick();
            chk("stall_ret_pc", bus.pc, 16'h0101);
            chk_ras("stall_ret", 16'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(PCS_CALL, 1'b0, 1'b0, 16'h0000, 16'h0600);
            chk("stall_call_nextpc", bus.nextpc, 16'h0600);
            tick();
            chk("stall_call_pc", bus.pc, 16'h0101);
            chk_ras("stall_call", 16'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(PCS_TRAP, 1'b0, 1'b0, 16'h0000, 16'h0000);
            chk("stall_trap_nextpc", bus.nextpc, 16'h0002);
            tick();
            chk("stall_trap_pc", bus.pc, 16'h0101);
        end
        drive(PCS_CALL, 1'b0, 1'b1, 16'h0000, 16'h0700);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(PCS_RET, 1'b0, 1'b0, 16'h0000, 16'h0AAA);
            chk("stall_pop_nextpc", bus.nextpc, 16'h0102);
            tick();
            chk("stall_pop_pc", bus.pc, 16'h0700);
            chk_ras("stall_pop", 16'd1, 1'b0, 1'b0);
        end
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0AAA);
        tick();
        chk("unstall_ret_pc", bus.pc, 16'h0102);
        chk_ras("unstall_ret", 16'd0, 1'b0, 1'b0);

        // Overflow: 9 calls into 8 entries, then 8 returns and one more.
        drive(PCS_JMP, 1'b0, 1'b1, 16'h0000, 16'h1000);
        tick();
        for (int k = 0; k < 9; k++) begin
            drive(PCS_CALL, 1'b0, 1'b1, 16'h0000, 16'h2000 + 16'(k * 16));
            tick();
            chk("ovf_call_pc", bus.pc, 16'h2000 + 16'(k * 16));
            if (k == 7) chk_ras("pre_ovf", 16'd8, 1'b0, 1'b0);
        end
        chk_ras("ovf", 16'd8, 1'b1, 1'b0);
        for (int k = 8; k >= 1; k--) begin
            drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0AAA);
            chk("ovf_ret_nextpc", bus.nextpc, 16'h2001 + 16'((k - 1) * 16));
            tick();
            chk("ovf_ret_pc", bus.pc, 16'h2001 + 16'((k - 1) * 16));
        end
        chk_ras("drained", 16'd0, 1'b1, 1'b0);
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0AAA);
        chk("unf_nextpc", bus.nextpc, 16'h0002);
        tick();
        chk("unf_pc", bus.pc, 16'h0002);
        chk_ras("unf", 16'd0, 1'b1, 1'b1);

        // Reset between a call and its return empties the stack.
        drive(PCS_CALL, 1'b0, 1'b1, 16'h0000, 16'h0800);
        tick();
        chk_ras("mid_call", 16'd1, 1'b1, 1'b1);
        drive(PCS_SEQ, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b0;
        #1;
        chk("mid_reset_pc", bus.pc, 16'h0010);
        chk_ras("mid_reset", 16'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0999);
        chk("post_reset_ret_nextpc", bus.nextpc, 16'h0002);
        tick();
        chk("post_reset_ret_pc", bus.pc, 16'h0002);
        chk_ras("post_reset_ret", 16'd0, 1'b0, 1'b1);
`else
        // Without the stack: CALL is a jump, RET goes to target.
        drive(PCS_CALL, 1'b0, 1'b1, 16'h0000, 16'h0400);
        chk("call_nextpc", bus.nextpc, 16'h0400);
        tick();
        chk("call_pc", bus.pc, 16'h0400);
        chk_ras("call", 16'd0, 1'b0, 1'b0);
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0123);
        chk("ret_nextpc", bus.nextpc, 16'h0123);
        tick();
        chk("ret_pc", bus.pc, 16'h0123);
        chk_ras("ret", 16'd0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            drive(PCS_CALL, 1'b0, 1'b1, 16'h0000, 16'h2000 + 16'(k * 16));
            tick();
            chk("many_call_pc", bus.pc, 16'h2000 + 16'(k * 16));
        end
        chk_ras("many_call", 16'd0, 1'b0, 1'b0);
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0321);
        tick();
        chk("ret2_pc", bus.pc, 16'h0321);
        chk_ras("ret2", 16'd0, 1'b0, 1'b0);

        // Stall with CALL, RET, TRAP selected.
        for (int k = 0; k < 3; k++) begin
            drive(PCS_RET, 1'b0, 1'b0, 16'h0000, 16'h0555);
            chk("stall_ret_nextpc", bus.nextpc, 16'h0555);
            tick();
            chk("stall_ret_pc", bus.pc, 16'h0321);
            drive(PCS_CALL, 1'b0, 1'b0, 16'h0000, 16'h0666);
            chk("stall_call_nextpc", bus.nextpc, 16'h0666);
            tick();
            chk("stall_call_pc", bus.pc, 16'h0321);
            drive(PCS_TRAP, 1'b0, 1'b0, 16'h0000, 16'h0000);
            chk("stall_trap_nextpc", bus.nextpc, 16'h0002);
            tick();
            chk("stall_trap_pc", bus.pc, 16'h0321);
        end
        chk_ras("stall", 16'd0, 1'b0, 1'b0);

        // Mid-operation reset.
        drive(PCS_SEQ, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b0;
        #1;
        chk("mid_reset_pc", bus.pc, 16'h0010);
        tick();
        reset = 1'b1;
        drive(PCS_RET, 1'b0, 1'b1, 16'h0000, 16'h0321);
        tick();
        chk("post_reset_ret_pc", bus.pc, 16'h0321);
        chk_ras("post_reset_ret", 16'd0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
